// File: rtl/rst_sequencer.sv
// Reset sequencer for the Wishbone clock domain.
// Watches the DCM and PLL lock indications and turns them into ordered
// synchronous resets: DDR2 interface first, then the Wishbone fabric, then
// the CPU. The PLL is reset again if lock never arrives. A lock loss or a
// software request starts the release sequence again.
module rst_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int LOCK_STABLE    = 16,
    parameter int STAGE_DELAY    = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int PLL_RST_CYCLES = 8,
    parameter int CNT_W          = 17
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_n_i,
    input  logic       dcm_locked_i,
    input  logic       pll_locked_i,
    input  logic       sw_rst_req_i,
    output logic       pll_rst_o,
    output logic       ddr2_rst_o,
    output logic       wb_rst_o,
    output logic       cpu_rst_o,
    output logic       done_o,
    output logic [2:0] state_o,
    output logic [7:0] lock_lost_cnt_o
);

    // ------------------------------------------------------------------
    // State encoding; the numeric values are visible on state_o.
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_REL_DDR2  = 3'd2,
        ST_REL_WB    = 3'd3,
        ST_REL_CPU   = 3'd4,
        ST_RUN       = 3'd5
    } state_t;

    // The stability counter only needs to reach LOCK_STABLE-1: the cycle on
    // which it would reach LOCK_STABLE is the release cycle itself.
    localparam int STAB_W = (LOCK_STABLE < 2) ? 1 : $clog2(LOCK_STABLE);

    // Terminal counts: a phase lasting N cycles ends when the counter shows N-1.
    localparam logic [STAB_W-1:0] STAB_LAST    = STAB_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0]  PLL_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  STAGE_LAST   = CNT_W'(STAGE_DELAY - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] dcm_sync_q;
    logic [SYNC_STAGES-1:0] pll_sync_q;

    state_t                 state_q;
    state_t                 state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic [STAB_W-1:0]      stab_q;
    logic [STAB_W-1:0]      stab_d;
    logic [7:0]             lost_q;
    logic [7:0]             lost_d;
    logic                   sw_take_d;

    logic                   pll_rst_q;
    logic                   ddr2_rst_q;
    logic                   wb_rst_q;
    logic                   cpu_rst_q;
    logic                   done_q;

    logic                   lock_ok;
    logic [7:0]             lost_inc;

    // ------------------------------------------------------------------
    // Lock input synchronisers: a plain shift chain per lock bit.
    // Cleared during reset so the sequencer always starts from "unlocked".
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            dcm_sync_q <= '0;
            pll_sync_q <= '0;
        end else begin
            dcm_sync_q <= {dcm_sync_q[SYNC_STAGES-2:0], dcm_locked_i};
            pll_sync_q <= {pll_sync_q[SYNC_STAGES-2:0], pll_locked_i};
        end
    end

    // Both clock sources must report lock for the system to be usable.
    assign lock_ok = dcm_sync_q[SYNC_STAGES-1] & pll_sync_q[SYNC_STAGES-1];

    // Lock-loss events saturate rather than wrap so a flapping clock is
    // never mistaken for a quiet one.
    assign lost_inc = (lost_q == 8'hFF) ? lost_q : lost_q + 8'd1;

    // ------------------------------------------------------------------
    // Next-state decode. The shared counter clears on every state change;
    // the stability counter only lives in WAIT_LOCK.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        stab_d    = '0;
        lost_d    = lost_q;
        sw_take_d = 1'b0;

        case (state_q)
            ST_RESET_PLL: begin
                if (cnt_q == PLL_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end

            ST_WAIT_LOCK: begin
                stab_d = lock_ok ? stab_q + 1'b1 : '0;
                // Release is checked first so it wins over a coincident timeout.
                if (lock_ok && (stab_q == STAB_LAST)) begin
                    state_d = ST_REL_DDR2;
                    cnt_d   = '0;
                    stab_d  = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = ST_RESET_PLL;
                    cnt_d   = '0;
                    stab_d  = '0;
                end
            end

            ST_REL_DDR2, ST_REL_WB, ST_REL_CPU: begin
                if (!lock_ok) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                    lost_d  = lost_inc;
                end else if (cnt_q == STAGE_LAST) begin
                    cnt_d = '0;
                    case (state_q)
                        ST_REL_DDR2: state_d = ST_REL_WB;
                        ST_REL_WB:   state_d = ST_REL_CPU;
                        default:     state_d = ST_RUN;
                    endcase
                end
            end

            ST_RUN: begin
                // Counter is idle here; holding it at zero keeps it from wrapping.
                cnt_d = '0;
                // Lock loss takes priority over a software request.
                if (!lock_ok) begin
                    state_d = ST_WAIT_LOCK;
                    lost_d  = lost_inc;
                end else if (sw_rst_req_i) begin
                    // DDR2 stays out of reset; only fabric and CPU are re-sequenced.
                    state_d   = ST_REL_WB;
                    sw_take_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_RESET_PLL;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, counters and registered outputs. Outputs are decoded from the
    // next state so they change on the same edge as state_o.
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state_q    <= ST_RESET_PLL;
            cnt_q      <= '0;
            stab_q     <= '0;
            lost_q     <= '0;
            pll_rst_q  <= 1'b1;
            ddr2_rst_q <= 1'b1;
            wb_rst_q   <= 1'b1;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            stab_q     <= stab_d;
            lost_q     <= lost_d;
            pll_rst_q  <= (state_d == ST_RESET_PLL);
            ddr2_rst_q <= (state_d == ST_RESET_PLL) || (state_d == ST_WAIT_LOCK);
            // A software request re-asserts the fabric reset for the first
            // cycle of REL_WB only, so downstream logic sees a real pulse.
            wb_rst_q   <= (state_d == ST_RESET_PLL) || (state_d == ST_WAIT_LOCK) ||
                          (state_d == ST_REL_DDR2)  || sw_take_d;
            cpu_rst_q  <= (state_d != ST_REL_CPU) && (state_d != ST_RUN);
            done_q     <= (state_d == ST_RUN);
        end
    end

    assign pll_rst_o       = pll_rst_q;
    assign ddr2_rst_o      = ddr2_rst_q;
    assign wb_rst_o        = wb_rst_q;
    assign cpu_rst_o       = cpu_rst_q;
    assign done_o          = done_q;
    assign state_o         = state_q;
    assign lock_lost_cnt_o = lost_q;

endmodule
